// File: rtl/seg7_pattern_rx.sv
// Reads back an active-low 7-segment pattern: synchronizes, debounces and decodes each
// newly stable glyph, then presents it through a one-entry VALID/READY holding register.
//
// state | meaning
// ------+--------------------------------------------------------------
// TRACK | watching S; emit once it is stable and differs from LAST
// EMIT  | one cycle: decode S, record it as LAST, offer to holding reg
// HOLD  | current pattern already emitted; wait for S to leave LAST
module seg7_pattern_rx #(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [6:0] SEG_IN,
    input  logic       OUT_READY,
    input  logic       CLR_OVR,
    output logic       OUT_VALID,
    output logic [3:0] OUT_CODE,
    output logic [1:0] OUT_KIND,
    output logic       OVERRUN
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_EMIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [6:0]    sync1_q, sync1_d;
    logic [6:0]    s_q, s_d;
    logic [6:0]    s_prev_q, s_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [6:0]    last_q, last_d;
    logic          last_vld_q, last_vld_d;
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic [1:0]    kind_q, kind_d;
    logic          ovr_q, ovr_d;

    logic          stable;
    logic          new_pat;
    logic          offer;
    logic          load;
    logic [3:0]    dec_code;
    logic [1:0]    dec_kind;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q    <= 7'h7F;
            s_q        <= 7'h7F;
            s_prev_q   <= 7'h7F;
            cnt_q      <= '0;
            state_q    <= ST_TRACK;
            last_q     <= 7'h7F;
            last_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            code_q     <= 4'h0;
            kind_q     <= 2'b00;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            s_q        <= s_d;
            s_prev_q   <= s_prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            kind_q     <= kind_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        sync1_d  = SEG_IN;
        s_d      = sync1_q;
        s_prev_d = s_q;
        if (s_q != s_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The count is stale on the cycle S changes, so stability also requires S == previous S.
    assign stable  = (s_q == s_prev_q) && (cnt_q == CNT_MAX);
    assign new_pat = !last_vld_q || (s_q != last_q);

    always_comb begin
        dec_code = 4'h0;
        dec_kind = 2'b00;
        case (s_q)
            7'b1000000: dec_code = 4'h0;
            7'b1111001: dec_code = 4'h1;
            7'b0100100: dec_code = 4'h2;
            7'b0110000: dec_code = 4'h3;
            7'b0011001: dec_code = 4'h4;
            7'b0010010: dec_code = 4'h5;
            7'b0000010: dec_code = 4'h6;
            7'b1111000: dec_code = 4'h7;
            7'b0000000: dec_code = 4'h8;
            7'b0010000: dec_code = 4'h9;
            7'b1000111: dec_code = 4'hA;
            7'b1001001: dec_code = 4'hC;
            7'b0001110: dec_code = 4'hD;
            7'b1000001: dec_code = 4'hE;
            7'b1111111: begin
                dec_code = 4'hF;
                dec_kind = 2'b01;
            end
            default: begin
                dec_code = 4'h0;
                dec_kind = 2'b10;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        offer      = 1'b0;
        case (state_q)
            ST_TRACK: begin
                if (stable && new_pat) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                offer      = 1'b1;
                last_d     = s_q;
                last_vld_d = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (new_pat) begin
                    state_d = ST_TRACK;
                end
            end
            default: state_d = ST_TRACK;
        endcase
    end

    assign load = offer && (!valid_q || OUT_READY);

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        kind_d  = kind_q;
        ovr_d   = ovr_q;
        if (load) begin
            valid_d = 1'b1;
            code_d  = dec_code;
            kind_d  = dec_kind;
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end
        if (offer && !load) begin
            ovr_d = 1'b1;
        end else if (CLR_OVR) begin
            ovr_d = 1'b0;
        end
    end

    assign OUT_VALID = valid_q;
    assign OUT_CODE  = code_q;
    assign OUT_KIND  = kind_q;
    assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// Bench for seg7_pattern_rx with STABLE_CYCLES=4: scenario tasks plus a scoreboard
// of expected {kind, code} popped whenever the DUT hands off an output.
module tb_seg7_pattern_rx;

    localparam int SC = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       out_ready;
    logic       clr_ovr;
    logic       out_valid;
    logic [3:0] out_code;
    logic [1:0] out_kind;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [5:0] exp_q[$];

    seg7_pattern_rx #(.STABLE_CYCLES(SC)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .SEG_IN    (seg_in),
        .OUT_READY (out_ready),
        .CLR_OVR   (clr_ovr),
        .OUT_VALID (out_valid),
        .OUT_CODE  (out_code),
        .OUT_KIND  (out_kind),
        .OVERRUN   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Handshake happens at the next rising edge; sample on the falling edge before it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [5:0] exp_v;
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got kind=%b code=%h, none expected", out_kind, out_code);
            end else begin
                exp_v = exp_q.pop_front();
                if ({out_kind, out_code} !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard: got kind=%b code=%h, expected kind=%b code=%h",
                             out_kind, out_code, exp_v[5:4], exp_v[3:0]);
                end
            end
        end
    end

    task automatic drive_seg(input logic [6:0] p);
        @(posedge clk);
        #1;
        seg_in = p;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        seg_in    = 7'h7F;
        out_ready = 1'b1;
        clr_ovr   = 1'b0;
        wait_cycles(3);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        if (out_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h, expected 0", out_code); end
        if (out_kind !== 2'b00) begin errors++; $display("FAIL reset_kind: got %b, expected 00", out_kind); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        rst_n = 1'b1;
    endtask

    task automatic test_latency;
        int first = -1;
        int high  = 0;
        drive_seg(7'b0100100);
        exp_q.push_back({2'b00, 4'h2});
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                high++;
                if (first < 0) first = e;
            end
        end
        checks += 2;
        if (first != SC + 3) begin errors++; $display("FAIL latency: valid rose after edge %0d, expected %0d", first, SC + 3); end
        if (high != 1) begin errors++; $display("FAIL pulse_width: valid high %0d cycles, expected 1", high); end
    endtask

    task automatic test_sequence;
        drive_seg(7'b1111001);
        exp_q.push_back({2'b00, 4'h1});
        wait_cycles(14);
        drive_seg(7'b1000111);
        exp_q.push_back({2'b00, 4'hA});
        wait_cycles(14);
        drive_seg(7'b1111111);
        exp_q.push_back({2'b01, 4'hF});
        wait_cycles(14);
    endtask

    task automatic test_glitch;
        int n0;
        drive_seg(7'b0110000);
        exp_q.push_back({2'b00, 4'h3});
        wait_cycles(14);
        n0 = pops;
        drive_seg(7'b0000000);
        wait_cycles(1);
        seg_in = 7'b0110000;
        wait_cycles(16);
        checks++;
        if (pops != n0) begin errors++; $display("FAIL glitch: %0d outputs during glitch, expected 0", pops - n0); end
    endtask

    task automatic test_unknown;
        drive_seg(7'b0101010);
        exp_q.push_back({2'b10, 4'h0});
        wait_cycles(14);
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        drive_seg(7'b0000010);
        exp_q.push_back({2'b00, 4'h6});
        wait_cycles(14);
        drive_seg(7'b0000000);
        wait_cycles(14);
        checks += 3;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b, expected 1", out_valid); end
        if (out_code !== 4'h6) begin errors++; $display("FAIL ovr_retain: got %h, expected 6", out_code); end
        // third offer lands on the same edge as the clear request
        drive_seg(7'b0010000);
        wait_cycles(SC + 3);
        clr_ovr = 1'b1;
        wait_cycles(1);
        clr_ovr = 1'b0;
        checks += 2;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b, expected 1", overrun); end
        if (out_code !== 4'h6) begin errors++; $display("FAIL ovr_retain2: got %h, expected 6", out_code); end
        drive_seg(7'b1001001);
        exp_q.push_back({2'b00, 4'hC});
        wait_cycles(SC + 3);
        out_ready = 1'b1;
        wait_cycles(1);
        out_ready = 1'b0;
        checks += 3;
        if (out_code !== 4'hC) begin errors++; $display("FAIL push_pop_code: got %h, expected c", out_code); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL push_pop_valid: got %b, expected 1", out_valid); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL push_pop_ovr: got %b, expected 1", overrun); end
        out_ready = 1'b1;
        wait_cycles(3);
        clr_ovr = 1'b1;
        wait_cycles(1);
        clr_ovr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b, expected 0", overrun); end
    endtask

    task automatic test_reset_mid;
        int first = -1;
        out_ready = 1'b0;
        drive_seg(7'b0010010);
        wait_cycles(14);
        checks++;
        if (out_code !== 4'h5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hold: got valid=%b code=%h, expected valid=1 code=5", out_valid, out_code);
        end
        drive_seg(7'b0000010);
        wait_cycles(3);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, expected 0", out_valid); end
        if (out_code !== 4'h0) begin errors++; $display("FAIL mid_reset_code: got %h, expected 0", out_code); end
        if (out_kind !== 2'b00) begin errors++; $display("FAIL mid_reset_kind: got %b, expected 00", out_kind); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_ovr: got %b, expected 0", overrun); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({2'b00, 4'h6});
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (out_valid && first < 0) first = e;
        end
        checks++;
        if (first != SC + 3) begin errors++; $display("FAIL reemit_latency: valid rose after edge %0d, expected %0d", first, SC + 3); end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_cycles(1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL drain: %0d expected outputs never seen", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sequence();
        test_glitch();
        test_unknown();
        test_overrun();
        test_reset_mid();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
